// File: rtl/regfile_dump_streamer_if.sv
// Valid/ready stream carrying one register-file dump entry per transfer.
interface regfile_dump_streamer_if #(
  parameter int IDX_W      = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_index;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, out_index, out_data, out_last, input out_ready);
  modport slave  (input  out_valid, out_index, out_data, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_streamer.sv
// Snapshots the register file on start and streams it out entry by entry,
// accumulating an XOR checksum over accepted entries.
module regfile_dump_snap_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (load) q <= d;
  end
endmodule

module regfile_dump_streamer #(
  parameter int REGISTER_FILE_SIZE = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int IDX_W              = $clog2(REGISTER_FILE_SIZE)
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            start,
  input  logic                                            abort,
  input  logic [REGISTER_FILE_SIZE-1:0][DATA_WIDTH-1:0]   debug_reg,
  regfile_dump_streamer_if.master                         dump,
  output logic                                            busy,
  output logic                                            done,
  output logic [DATA_WIDTH-1:0]                           checksum
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                                          state, state_n;
  logic [REGISTER_FILE_SIZE-1:0][DATA_WIDTH-1:0]   snap;
  logic [IDX_W-1:0]                                cnt;
  logic [DATA_WIDTH-1:0]                           snap_rd;
  logic                                            load, xfer, at_last;

  genvar g;
  generate
    for (g = 0; g < REGISTER_FILE_SIZE; g++) begin : g_lane
      regfile_dump_snap_lane #(.W(DATA_WIDTH)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .d       (debug_reg[g]),
        .q       (snap[g])
      );
    end
  endgenerate

  assign snap_rd = snap[cnt];
  assign at_last = (cnt == IDX_W'(REGISTER_FILE_SIZE-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // abort has priority over a coincident transfer
  always_comb begin
    state_n = state;
    load    = 1'b0;
    xfer    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = STREAM;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (abort) begin
          state_n = IDLE;
        end else if (dump.out_ready) begin
          xfer = 1'b1;
          if (at_last) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      checksum <= '0;
    end else if (load) begin
      cnt      <= '0;
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum ^ snap_rd;
      if (!at_last) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    dump.out_valid = (state == STREAM);
    dump.out_index = dump.out_valid ? cnt : '0;
    dump.out_data  = dump.out_valid ? snap_rd : '0;
    dump.out_last  = dump.out_valid && at_last;
    busy           = (state != IDLE);
    done           = (state == DONE);
  end
endmodule

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
- Reads the register file through its debug_reg port and streams the contents out as a sequenced dump.
- On a start request it takes a one-cycle snapshot of all registers, then emits one entry per accepted transfer on a valid/ready interface.
- Entries are tagged with index and last, and an XOR checksum is reported at completion.
- Sits beside register_file and feeds the verification/trace side of the core.

Parameters:
REGISTER_FILE_SIZE, 32 (from common), number of entries dumped; must be >= 2
DATA_WIDTH, 32, width of each register entry
IDX_W, $clog2(REGISTER_FILE_SIZE), width of the out_index field

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a dump; honoured only in IDLE
abort  input  1  synchronous cancel of a dump in progress
debug_reg  input  REGISTER_FILE_SIZE x DATA_WIDTH  register file contents
out_valid  output  1  out_index/out_data/out_last are valid
out_ready  input  1  consumer accepts the current entry
out_index  output  IDX_W  register number of the current entry
out_data  output  DATA_WIDTH  snapshot value of register out_index
out_last  output  1  current entry is index REGISTER_FILE_SIZE-1
busy  output  1  high in SNAP-free STREAM and DONE states
done  output  1  one-cycle pulse after the last entry is accepted
checksum  output  DATA_WIDTH  XOR of all entries accepted in the current/last dump

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0, all outputs are 0, the FSM is in IDLE, the snapshot buffer is cleared and checksum=0. Reset asserted mid-dump discards the dump immediately; no done pulse is produced.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - On a rising edge with start=1, copy debug_reg into the snapshot buffer, set the index counter to 0, clear checksum to 0, and go to STREAM.
  - out_valid rises in the cycle after the start edge (latency 1).
  - abort is ignored in IDLE.
- STREAM:
  - out_valid=1. out_index = counter. out_data = snapshot[counter]. out_last = (counter == REGISTER_FILE_SIZE-1).
  - Transfer occurs on a rising edge where out_valid && out_ready.
  - Hold rule: while out_valid=1 and out_ready=0, out_index, out_data and out_last stay stable.
  - On each transfer, checksum <= checksum ^ out_data, and counter increments.
  - Transfer with out_last=1: go to DONE. The counter does not wrap.
  - abort=1 on an edge in STREAM: go to IDLE and drop out_valid the next cycle; checksum keeps its partial value; no done pulse. If abort and a transfer coincide, abort wins: the transfer is not counted and checksum is not updated.
- DONE:
  - Lasts exactly one cycle: done=1, out_valid=0, busy=1, then IDLE.
  - checksum holds the final value from DONE until the next start.
- busy = 1 in STREAM and DONE; 0 in IDLE.
- start while busy is ignored and does not restart or re-snapshot.
- start in the same cycle the FSM returns to IDLE (the DONE cycle) is ignored. start is accepted only when the state register is IDLE.
- The snapshot is frozen after the start edge. Later register file writes do not affect the dump in progress.
- Entry 0 is dumped as captured (0 from a correct register file); the block does not force it.
- Minimum dump time is REGISTER_FILE_SIZE+1 cycles from start to done: back-to-back ready, one transfer per cycle.

Test Plan:
1. Load registers with x[i]=i*0x11111111 (mod 2^32), pulse start, hold out_ready=1 -> out_valid rises 1 cycle after start; 32 entries are emitted with index 0..31 and data x[i]; out_last only on index 31; done pulses 33 cycles after start; checksum = XOR of all x[i].
2. Same data, out_ready toggled 1,0,0,1,... -> index/data/last stay stable during stalls; each index appears exactly once; final checksum is identical to scenario 1.
3. Register file write to x5=0xDEADBEEF two cycles after start -> dump still shows the pre-start x5 value; next dump shows 0xDEADBEEF.
4. Assert abort together with a transfer at index 10 -> out_valid=0 next cycle; checksum = XOR of entries 0..9 only; no done pulse; a fresh start then dumps from index 0.
5. Pulse start during STREAM and again during the DONE cycle -> both are ignored; the dump completes once; busy falls after DONE.
6. Assert reset_n=0 asynchronously mid-dump at index 17 -> out_valid, busy, done, checksum and out_index go to 0 immediately without a clock edge; after release the block is in IDLE and a new start works normally.
